// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
// Direct-mapped read-cache controller. A miss refills the whole line from
// memory, one word per wait-state window. Each window is timed by an
// external wait-state counter, which this block loads and whose carry it
// consumes. The tag, valid and data arrays are held internally.
//
// Ports:
//   Clk, Rst       clock; asynchronous active-high reset
//   CpuReq         read request (sampled in IDLE only)
//   CpuAddr        byte address, bits [1:0] ignored
//   Flush          invalidate all lines (deferred while busy)
//   CpuReady       one-cycle pulse, CpuRdata valid in that cycle
//   CpuRdata       read data, held until the next response
//   MemReq         memory read request for the current refill word
//   MemAddr        word-aligned memory address
//   MemRdata       memory data, taken when WaitCarry=1 in REFILL_WAIT
//   WaitLoad       load strobe to the wait-state counter
//   WaitLoadValue  load value to the wait-state counter
//   WaitCarry      counter carry, high while the count is 0
module cache_refill_ctrl #(
    parameter int LINES       = 16,
    parameter int LINE_WORDS  = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        CpuReq,
    input  logic [31:0] CpuAddr,
    input  logic        Flush,
    output logic        CpuReady,
    output logic [31:0] CpuRdata,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic [31:0] MemRdata,
    output logic        WaitLoad,
    output logic [1:0]  WaitLoadValue,
    input  logic        WaitCarry
);

    localparam int INDEX_BITS = $clog2(LINES);
    localparam int OFF_BITS   = $clog2(LINE_WORDS);
    localparam int TAG_BITS   = 32 - INDEX_BITS - OFF_BITS - 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_ISSUE,
        REFILL_WAIT,
        RESP
    } state_t;

    state_t                state;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [OFF_BITS-1:0]   req_off;
    logic [OFF_BITS-1:0]   wordcnt;
    logic [OFF_BITS-1:0]   wordcnt_nxt;
    logic                  flush_pend;
    logic [LINES-1:0]      valid;

    logic [31:0]           data_mem [LINES*LINE_WORDS];
    logic [TAG_BITS-1:0]   tag_mem  [LINES];

    logic                  hit;
    logic                  word_done;
    logic                  last_word;
    logic [31:0]           line_word;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^CpuAddr[1:0];

    assign wordcnt_nxt = wordcnt + 1'b1;
    assign hit         = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign word_done   = (state == REFILL_WAIT) && WaitCarry;
    assign last_word   = (wordcnt == OFF_BITS'(LINE_WORDS - 1));
    assign line_word   = data_mem[{req_idx, req_off}];

    // Data and tag arrays carry no reset; writes only happen in REFILL_WAIT,
    // which reset forces the FSM out of.
    always_ff @(posedge Clk) begin
        if (word_done) begin
            data_mem[{req_idx, wordcnt}] <= MemRdata;
            if (last_word) begin
                tag_mem[req_idx] <= req_tag;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state         <= IDLE;
            req_tag       <= '0;
            req_idx       <= '0;
            req_off       <= '0;
            wordcnt       <= '0;
            flush_pend    <= 1'b0;
            valid         <= '0;
            CpuReady      <= 1'b0;
            CpuRdata      <= '0;
            MemReq        <= 1'b0;
            MemAddr       <= '0;
            WaitLoad      <= 1'b0;
            WaitLoadValue <= '0;
        end else begin
            CpuReady <= 1'b0;
            WaitLoad <= 1'b0;

            if (Flush && (state != IDLE)) begin
                flush_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (Flush || flush_pend) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                    end else if (CpuReq) begin
                        req_off <= CpuAddr[OFF_BITS+1:2];
                        req_idx <= CpuAddr[OFF_BITS+INDEX_BITS+1:OFF_BITS+2];
                        req_tag <= CpuAddr[31:OFF_BITS+INDEX_BITS+2];
                        state   <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (hit) begin
                        CpuReady <= 1'b1;
                        CpuRdata <= line_word;
                        state    <= RESP;
                    end else begin
                        wordcnt       <= '0;
                        MemReq        <= 1'b1;
                        MemAddr       <= {req_tag, req_idx, {OFF_BITS{1'b0}}, 2'b00};
                        WaitLoad      <= 1'b1;
                        WaitLoadValue <= 2'(WAIT_CYCLES);
                        state         <= REFILL_ISSUE;
                    end
                end

                REFILL_ISSUE: begin
                    // Carry still reflects the previous count here.
                    state <= REFILL_WAIT;
                end

                REFILL_WAIT: begin
                    if (WaitCarry) begin
                        if (last_word) begin
                            valid[req_idx] <= 1'b1;
                            MemReq         <= 1'b0;
                            CpuReady       <= 1'b1;
                            // The final word is written on this same edge, so
                            // bypass it straight from memory when requested.
                            CpuRdata       <= (req_off == wordcnt) ? MemRdata : line_word;
                            state          <= RESP;
                        end else begin
                            wordcnt       <= wordcnt_nxt;
                            MemAddr       <= {req_tag, req_idx, wordcnt_nxt, 2'b00};
                            WaitLoad      <= 1'b1;
                            WaitLoadValue <= 2'(WAIT_CYCLES);
                            state         <= REFILL_ISSUE;
                        end
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    MemReq <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

    localparam int LW    = 4;
    localparam int NLINE = 16;

    logic        clk;
    logic        rst        [2];
    logic        cpu_req    [2];
    logic [31:0] cpu_addr   [2];
    logic        flush      [2];
    logic        cpu_ready  [2];
    logic [31:0] cpu_rdata  [2];
    logic        mem_req    [2];
    logic [31:0] mem_addr   [2];
    logic [31:0] mem_rdata  [2];
    logic        wait_load  [2];
    logic [1:0]  wait_lv    [2];
    logic        wait_carry [2];
    logic [1:0]  cnt        [2];

    logic [31:0] seed;
    int          total;
    int          passed;

    // reference cache state: valid flag and tag (addr >> 8) per line
    bit          mvalid [2][NLINE];
    logic [31:0] mtag   [2][NLINE];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cache_refill_ctrl #(.LINES(16), .LINE_WORDS(4), .WAIT_CYCLES(2)) u0 (
        .Clk(clk), .Rst(rst[0]), .CpuReq(cpu_req[0]), .CpuAddr(cpu_addr[0]),
        .Flush(flush[0]), .CpuReady(cpu_ready[0]), .CpuRdata(cpu_rdata[0]),
        .MemReq(mem_req[0]), .MemAddr(mem_addr[0]), .MemRdata(mem_rdata[0]),
        .WaitLoad(wait_load[0]), .WaitLoadValue(wait_lv[0]), .WaitCarry(wait_carry[0])
    );

    cache_refill_ctrl #(.LINES(16), .LINE_WORDS(4), .WAIT_CYCLES(0)) u1 (
        .Clk(clk), .Rst(rst[1]), .CpuReq(cpu_req[1]), .CpuAddr(cpu_addr[1]),
        .Flush(flush[1]), .CpuReady(cpu_ready[1]), .CpuRdata(cpu_rdata[1]),
        .MemReq(mem_req[1]), .MemAddr(mem_addr[1]), .MemRdata(mem_rdata[1]),
        .WaitLoad(wait_load[1]), .WaitLoadValue(wait_lv[1]), .WaitCarry(wait_carry[1])
    );

    function automatic logic [31:0] memfn(input logic [31:0] a, input logic [31:0] s);
        return (a * 32'h9E37_79B1) ^ s ^ {a[15:0], a[31:16]};
    endfunction

    function automatic int wcyc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    assign mem_rdata[0]  = memfn(mem_addr[0], seed);
    assign mem_rdata[1]  = memfn(mem_addr[1], seed);
    assign wait_carry[0] = (cnt[0] == 2'd0);
    assign wait_carry[1] = (cnt[1] == 2'd0);

    // external wait-state down-counter
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d])                cnt[d] <= 2'd3;
            else if (wait_load[d])     cnt[d] <= wait_lv[d];
            else if (cnt[d] != 2'd0)   cnt[d] <= cnt[d] - 2'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clear(input int d);
        for (int i = 0; i < NLINE; i++) mvalid[d][i] = 1'b0;
    endtask

    // One read transaction. Cycle k is the k-th cycle after the edge that
    // samples CpuReq. flush_cyc / rst_cyc: cycle in which to pulse Flush /
    // assert Rst (0 = never). fwr: assert Flush together with the request.
    task automatic do_read(input int d, input logic [31:0] addr, input int flush_cyc,
                           input int rst_cyc, input bit fwr);
        int          idx;
        logic [31:0] tg;
        logic [31:0] base;
        bit          hit;
        bit          flushed;
        int          w;
        int          exp_lat;
        int          lat;
        int          mr_cycles;
        int          addr_err;
        int          wl_err;
        int          seq_err;
        logic [31:0] cur;
        logic [31:0] q[$];
        logic [31:0] rdata;
        string       nm;

        idx       = int'((addr >> 4) & 32'hF);
        tg        = addr >> 8;
        base      = addr & 32'hFFFF_FFF0;
        w         = wcyc(d);
        lat       = -1;
        mr_cycles = 0;
        addr_err  = 0;
        wl_err    = 0;
        seq_err   = 0;
        flushed   = 1'b0;
        cur       = '0;
        rdata     = '0;
        nm        = $sformatf("u%0d@%h", d, addr);

        @(negedge clk);
        cpu_req[d]  = 1'b1;
        cpu_addr[d] = addr;
        if (fwr) flush[d] = 1'b1;
        @(posedge clk);
        if (fwr) begin
            // flush edge: request must wait one more cycle
            @(negedge clk);
            flush[d] = 1'b0;
            model_clear(d);
            @(posedge clk);
        end
        hit     = mvalid[d][idx] && (mtag[d][idx] == tg);
        exp_lat = hit ? 2 : 2 + LW * (w + 2);

        for (int k = 1; k <= 100 && lat < 0; k++) begin
            @(negedge clk);
            if (cpu_ready[d]) begin
                lat   = k;
                rdata = cpu_rdata[d];
            end
            if (wait_load[d]) begin
                q.push_back(mem_addr[d]);
                cur = mem_addr[d];
                if (wait_lv[d] !== 2'(w)) wl_err++;
            end
            if (mem_req[d]) begin
                mr_cycles++;
                if (mem_addr[d] !== cur) addr_err++;
            end
            if (k == 1) cpu_req[d] = 1'b0;
            flush[d] = (k == flush_cyc);
            if (k == flush_cyc) flushed = 1'b1;
            if (k == rst_cyc) begin
                #2;
                rst[d] = 1'b1;
                #1;
                check({nm, " rst CpuReady"}, 32'(cpu_ready[d]), 32'd0);
                check({nm, " rst MemReq"},   32'(mem_req[d]),   32'd0);
                check({nm, " rst WaitLoad"}, 32'(wait_load[d]), 32'd0);
                check({nm, " rst MemAddr"},  mem_addr[d],       32'd0);
                check({nm, " rst CpuRdata"}, cpu_rdata[d],      32'd0);
                check({nm, " rst WaitLV"},   32'(wait_lv[d]),   32'd0);
                @(negedge clk);
                rst[d]   = 1'b0;
                flush[d] = 1'b0;
                model_clear(d);
                return;
            end
        end

        check({nm, " latency"}, 32'(lat), 32'(exp_lat));
        check({nm, " rdata"}, rdata, memfn(addr & 32'hFFFF_FFFC, seed));
        check({nm, " loads"}, 32'(q.size()), hit ? 32'd0 : 32'(LW));
        for (int i = 0; i < q.size(); i++)
            if (q[i] !== base + 32'(4 * i)) seq_err++;
        check({nm, " addr seq"}, 32'(seq_err), 32'd0);
        check({nm, " memreq cycles"}, 32'(mr_cycles), hit ? 32'd0 : 32'(LW * (w + 2)));
        check({nm, " addr stable"}, 32'(addr_err), 32'd0);
        check({nm, " loadval"}, 32'(wl_err), 32'd0);

        if (!hit) begin
            mvalid[d][idx] = 1'b1;
            mtag[d][idx]   = tg;
        end
        if (flushed) model_clear(d);

        // cycle after the response: pulse over, data held; a pending flush
        // executes on this IDLE cycle's closing edge
        @(negedge clk);
        flush[d] = 1'b0;
        check({nm, " ready pulse"}, 32'(cpu_ready[d]), 32'd0);
        check({nm, " rdata hold"}, cpu_rdata[d], rdata);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        seed   = $urandom;
        for (int d = 0; d < 2; d++) begin
            rst[d]      = 1'b1;
            cpu_req[d]  = 1'b0;
            cpu_addr[d] = '0;
            flush[d]    = 1'b0;
            model_clear(d);
            for (int i = 0; i < NLINE; i++) mtag[d][i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("u%0d reset CpuReady", d), 32'(cpu_ready[d]), 32'd0);
            check($sformatf("u%0d reset MemReq", d),   32'(mem_req[d]),   32'd0);
            check($sformatf("u%0d reset WaitLoad", d), 32'(wait_load[d]), 32'd0);
            check($sformatf("u%0d reset CpuRdata", d), cpu_rdata[d],      32'd0);
            check($sformatf("u%0d reset MemAddr", d),  mem_addr[d],       32'd0);
            check($sformatf("u%0d reset WaitLV", d),   32'(wait_lv[d]),   32'd0);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // cold miss, hit, conflict eviction, re-miss (WAIT_CYCLES=2)
        do_read(0, 32'h0000_0104, 0, 0, 1'b0);
        do_read(0, 32'h0000_010C, 0, 0, 1'b0);
        do_read(0, 32'h0000_0500, 0, 0, 1'b0);
        do_read(0, 32'h0000_0100, 0, 0, 1'b0);
        // WAIT_CYCLES=0
        do_read(1, 32'h0000_0104, 0, 0, 1'b0);
        do_read(1, 32'h0000_0108, 0, 0, 1'b0);
        // flush during the 2nd refill word, then re-read misses
        do_read(0, 32'h0000_020C, 7, 0, 1'b0);
        do_read(0, 32'h0000_020C, 0, 0, 1'b0);
        do_read(0, 32'h0000_0204, 0, 0, 1'b0);
        // flush together with request on a valid line: serviced first
        do_read(0, 32'h0000_0204, 0, 0, 1'b1);
        // reset mid-refill, then full refill
        do_read(0, 32'h0000_3008, 0, 8, 1'b0);
        do_read(0, 32'h0000_3008, 0, 0, 1'b0);
        do_read(1, 32'h0000_3008, 0, 3, 1'b0);
        do_read(1, 32'h0000_3008, 0, 0, 1'b0);

        // randomized traffic over a small address pool
        for (int n = 0; n < 40; n++) begin
            int          d;
            int          fc;
            logic [31:0] a;
            d  = int'($urandom_range(0, 1));
            a  = {20'h0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            fc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 10)) : 0;
            do_read(d, a, fc, 0, ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
